bcd_down_counter: RTL

- Two-digit BCD down-counter with load, start/stop control and a borrow output.
- Provides countdown-timer and alarm-set digits for the 7-segment clock: the decrementing counterpart of the up-counting BCD stages.
- Cascades the same way as the up-counters. A stage's underflow_o drives the next stage's decrement_i, so a seconds/minutes countdown chain can be built from it.
- Feeds the display path through both digit outputs and a binary mirror.

---
 rtl/bcd_down_counter_if.sv | 30 +++
 rtl/bcd_down_counter.sv | 98 +++++++++
 2 files changed

// File: rtl/bcd_down_counter_if.sv
// Signal bundle for the two-digit BCD down-counter: load/control strobes in,
// digit, binary and status outputs back.
interface bcd_down_counter_if;
  logic       load_i;
  logic [3:0] load_tens_i;
  logic [3:0] load_ones_i;
  logic       start_i;
  logic       stop_i;
  logic       decrement_i;
  logic [3:0] count_tens_o;
  logic [3:0] count_ones_o;
  logic [6:0] count_o;
  logic       running_o;
  logic       done_o;
  logic       zero_o;
  logic       underflow_o;
  logic       load_err_o;

  modport master (
    output load_i, load_tens_i, load_ones_i, start_i, stop_i, decrement_i,
    input  count_tens_o, count_ones_o, count_o, running_o, done_o, zero_o,
           underflow_o, load_err_o
  );

  modport slave (
    input  load_i, load_tens_i, load_ones_i, start_i, stop_i, decrement_i,
    output count_tens_o, count_ones_o, count_o, running_o, done_o, zero_o,
           underflow_o, load_err_o
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down-counter with load, start/stop and a combinational borrow
// so stages can be chained (underflow of one drives decrement of the next).
module bcd_down_counter #(
  parameter int MAX_COUNT = 99,
  parameter bit WRAP      = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  bcd_down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digits of the wrap-reload value.
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
  localparam logic [7:0] MAX_VAL  = 8'(MAX_COUNT);

  state_t     state, state_nxt;
  logic [3:0] tens, tens_nxt;
  logic [3:0] ones, ones_nxt;
  logic       load_err, load_err_nxt;
  logic [7:0] load_val;
  logic       load_ok;
  logic       is_zero;

  // Binary value of the requested load; 8 bits covers two raw nibbles (<=165).
  assign load_val = ({4'd0, bus.load_tens_i} * 8'd10) + {4'd0, bus.load_ones_i};
  assign load_ok  = (bus.load_tens_i <= 4'd9) && (bus.load_ones_i <= 4'd9) &&
                    (load_val <= MAX_VAL);
  assign is_zero  = (tens == 4'd0) && (ones == 4'd0);

  // Next-state and next-count selection; load beats stop beats start beats tick.
  always_comb begin
    state_nxt    = state;
    tens_nxt     = tens;
    ones_nxt     = ones;
    load_err_nxt = 1'b0;
    if (bus.load_i) begin
      if (load_ok) begin
        tens_nxt  = bus.load_tens_i;
        ones_nxt  = bus.load_ones_i;
        state_nxt = IDLE;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (bus.stop_i && (state == RUN)) begin
      state_nxt = IDLE;
    end else if (bus.start_i && (state == IDLE)) begin
      state_nxt = RUN;
    end else if (bus.decrement_i && (state == RUN)) begin
      if (is_zero) begin
        if (WRAP) begin
          tens_nxt = MAX_TENS;
          ones_nxt = MAX_ONES;
        end else begin
          state_nxt = DONE;
        end
      end else if (ones != 4'd0) begin
        ones_nxt = ones - 4'd1;
      end else begin
        ones_nxt = 4'd9;
        tens_nxt = tens - 4'd1;
      end
    end
  end

  // State, digit and error-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      tens     <= 4'd0;
      ones     <= 4'd0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      tens     <= tens_nxt;
      ones     <= ones_nxt;
      load_err <= load_err_nxt;
    end
  end

  assign bus.count_tens_o = tens;
  assign bus.count_ones_o = ones;
  assign bus.count_o      = ({3'd0, tens} * 7'd10) + {3'd0, ones};
  assign bus.running_o    = (state == RUN);
  assign bus.done_o       = (state == DONE);
  assign bus.zero_o       = is_zero;
  assign bus.load_err_o   = load_err;
  // Unregistered so a cascaded stage borrows on the same edge.
  assign bus.underflow_o  = (state == RUN) && bus.decrement_i && is_zero &&
                            !bus.load_i && !bus.stop_i;

endmodule
